// File: rtl/msx_pkg.sv
// msx_pkg: shared types for the MSX core wait-state logic
//   wait_state_t : wait generator FSM states
//   wait_class_t : Z80 bus cycle classes, listed in detection priority order
package msx_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} wait_state_t;
    typedef enum logic [1:0] {NONE, M1, IO, MEM} wait_class_t;
endpackage

// File: rtl/msx_wait_gen.sv
// msx_wait_gen: per-class programmable Z80 wait-state generator with external wait merge
//   clk21m, reset     : system clock, async active-high reset
//   ce_3m58_p         : CPU clock enable, all state steps on it
//   m1_n..rfrsh_n     : T80 bus strobes (active-low)
//   exwait_n          : external wait request, merged combinationally into wait_n
//   enable            : 0 disables all internal waits
//   m1_waits/io_waits/mem_waits : wait counts per cycle class
//   wait_n, in_wait, wait_total : CPU WAIT_n, internal-wait flag, wrapping wait-tick counter
module msx_wait_gen
    import msx_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int STAT_W = 16
) (
    input  logic              clk21m,
    input  logic              reset,
    input  logic              ce_3m58_p,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfrsh_n,
    input  logic              exwait_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  m1_waits,
    input  logic [CNT_W-1:0]  io_waits,
    input  logic [CNT_W-1:0]  mem_waits,
    output logic              wait_n,
    output logic              in_wait,
    output logic [STAT_W-1:0] wait_total
);
    function automatic wait_class_t classify(input logic m1, mreq, iorq, rd, wr, rfsh);
        return (!m1 && (!mreq || !iorq))                  ? M1  :
               (m1 && !iorq && (!rd || !wr))              ? IO  :
               (m1 && !mreq && rfsh && (!rd || !wr))      ? MEM : NONE;
    endfunction

    wait_state_t      state;
    wait_class_t      cls;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n;
    logic             int_wait_n;

    always_comb begin
        cls = classify(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfrsh_n);
        n   = !enable      ? '0        :
              (cls == M1)  ? m1_waits  :
              (cls == IO)  ? io_waits  :
              (cls == MEM) ? mem_waits : '0;
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            int_wait_n <= 1'b1;
            in_wait    <= 1'b0;
            wait_total <= '0;
        end else if (ce_3m58_p) begin
            case (state)
                IDLE: if (cls != NONE) begin
                    if (n != '0) begin
                        state      <= WAIT;
                        cnt        <= n;
                        int_wait_n <= 1'b0;
                        in_wait    <= 1'b1;
                    end else begin
                        state <= HOLD;
                    end
                end
                WAIT: begin
                    cnt        <= cnt - 1'b1;
                    wait_total <= wait_total + 1'b1;
                    if (cnt == 1) begin
                        int_wait_n <= 1'b1;
                        in_wait    <= 1'b0;
                        state      <= HOLD;
                    end
                end
                // Wait for the bus to go idle so one bus cycle is never counted twice
                HOLD: if (mreq_n && iorq_n) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign wait_n = int_wait_n & exwait_n;
endmodule

// File: tb/tb_msx_wait_gen.sv
// tb_msx_wait_gen: randomized and directed bench for msx_wait_gen against a tick-count model
module tb_msx_wait_gen;
    localparam int SW = 8;

    logic          clk21m = 1'b0;
    logic          reset = 1'b1;
    logic          ce_3m58_p = 1'b0;
    logic          m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
    logic          rd_n = 1'b1, wr_n = 1'b1, rfrsh_n = 1'b1;
    logic          exwait_n = 1'b1;
    logic          enable = 1'b1;
    logic [2:0]    m1_waits = 3'd1, io_waits = 3'd0, mem_waits = 3'd0;
    logic          wait_n, in_wait;
    logic [SW-1:0] wait_total;

    msx_wait_gen #(.CNT_W(3), .STAT_W(SW)) dut (
        .clk21m(clk21m), .reset(reset), .ce_3m58_p(ce_3m58_p),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfrsh_n(rfrsh_n),
        .exwait_n(exwait_n), .enable(enable),
        .m1_waits(m1_waits), .io_waits(io_waits), .mem_waits(mem_waits),
        .wait_n(wait_n), .in_wait(in_wait), .wait_total(wait_total)
    );

    always #5 clk21m = ~clk21m;

    int checks = 0, errors = 0;
    int ce_mode = 0, phase = 0;
    int lowcnt = 0, inwcnt = 0;

    // Model: a bus cycle detected at tick t0 with N waits keeps the internal wait low
    // until tick t0+N; detection re-arms on the first idle-bus tick after that.
    longint        mt;
    bit            m_free;
    longint        m_start, m_end;
    logic [SW-1:0] m_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int bus_cls();
        if (!m1_n && (!mreq_n || !iorq_n)) return 1;
        if (m1_n && !iorq_n && (!rd_n || !wr_n)) return 2;
        if (m1_n && !mreq_n && rfrsh_n && (!rd_n || !wr_n)) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        mt = 0; m_free = 1; m_start = 0; m_end = 0; m_total = '0;
    endtask

    task automatic model_tick();
        int c, n;
        if (reset) model_reset();
        else if (ce_3m58_p) begin
            mt++;
            if (m_free) begin
                c = bus_cls();
                if (c != 0) begin
                    n = !enable ? 0 : c == 1 ? int'(m1_waits) : c == 2 ? int'(io_waits) : int'(mem_waits);
                    m_free = 0; m_start = mt; m_end = mt + n;
                end
            end else begin
                if (mt > m_start && mt <= m_end) m_total++;
                if (mt > m_end && mreq_n && iorq_n) m_free = 1;
            end
        end
    endtask

    task automatic clk1();
        bit low;
        @(posedge clk21m);
        model_tick();
        #1;
        low = !m_free && (mt < m_end);
        check("wait_n", 32'(wait_n), 32'(!low & exwait_n));
        check("in_wait", 32'(in_wait), 32'(low));
        check("wait_total", 32'(wait_total), 32'(m_total));
        lowcnt += int'(!wait_n);
        inwcnt += int'(in_wait);
        phase = (phase + 1) % 6;
        ce_3m58_p = ce_mode == 0 ? (phase == 0) : ce_mode == 1 ? 1'b1 : ($urandom_range(0, 2) == 0);
    endtask

    task automatic run(input int n);
        repeat (n) clk1();
    endtask

    task automatic bus(input logic m1, mreq, iorq, rd, wr, rf);
        m1_n = m1; mreq_n = mreq; iorq_n = iorq; rd_n = rd; wr_n = wr; rfrsh_n = rf;
    endtask

    task automatic idle();
        bus(1, 1, 1, 1, 1, 1);
    endtask

    initial begin
        model_reset();
        run(3);
        check("reset wait_n", 32'(wait_n), 32'd1);
        check("reset in_wait", 32'(in_wait), 32'd0);
        check("reset wait_total", 32'(wait_total), 32'd0);
        reset = 1'b0;
        run(12);

        // M1 fetch, one wait, then a zero-wait memory read
        lowcnt = 0;
        bus(0, 0, 1, 0, 1, 1); run(24); idle(); run(12);
        check("m1 low clocks", 32'(lowcnt), 32'd6);
        lowcnt = 0;
        bus(1, 0, 1, 0, 1, 1); run(24); idle(); run(12);
        check("mem0 low clocks", 32'(lowcnt), 32'd0);
        check("m1 total", 32'(wait_total), 32'd1);

        // IO write, five waits
        io_waits = 3'd5; mem_waits = 3'd2; lowcnt = 0; inwcnt = 0;
        bus(1, 1, 0, 1, 0, 1); run(48); idle(); run(12);
        check("io low clocks", 32'(lowcnt), 32'd30);
        check("io in_wait clocks", 32'(inwcnt), 32'd30);
        check("io total", 32'(wait_total), 32'd6);

        // Refresh never waits
        mem_waits = 3'd3; lowcnt = 0; inwcnt = 0;
        bus(1, 0, 1, 0, 1, 0); run(24); idle(); run(12);
        check("refresh low clocks", 32'(lowcnt), 32'd0);
        check("refresh in_wait clocks", 32'(inwcnt), 32'd0);

        // External wait longer than the internal two waits
        m1_waits = 3'd2; lowcnt = 0; inwcnt = 0;
        bus(0, 0, 1, 0, 1, 1); exwait_n = 1'b0; run(48);
        exwait_n = 1'b1; idle(); run(12);
        check("exwait low clocks", 32'(lowcnt), 32'd48);
        check("exwait in_wait clocks", 32'(inwcnt), 32'd12);
        check("exwait total", 32'(wait_total), 32'd8);

        // Async reset two ticks into a seven-wait memory cycle
        mem_waits = 3'd7;
        bus(1, 0, 1, 0, 1, 1); run(18);
        check("pre-reset total", 32'(wait_total), 32'd10);
        reset = 1'b1; #1;
        check("async reset wait_n", 32'(wait_n), 32'd1);
        check("async reset in_wait", 32'(in_wait), 32'd0);
        check("async reset total", 32'(wait_total), 32'd0);
        idle(); run(3); reset = 1'b0; run(12);
        lowcnt = 0;
        bus(1, 0, 1, 0, 1, 1); run(48); idle(); run(12);
        check("post-reset mem low clocks", 32'(lowcnt), 32'd42);
        check("post-reset total", 32'(wait_total), 32'd7);

        // Turbo: no internal waits at all
        enable = 1'b0; m1_waits = 3'd7; io_waits = 3'd7; lowcnt = 0;
        bus(0, 0, 1, 0, 1, 1); run(24); idle(); run(12);
        bus(1, 1, 0, 0, 1, 1); run(24); idle(); run(12);
        bus(1, 0, 1, 1, 0, 1); run(24); idle(); run(12);
        check("turbo low clocks", 32'(lowcnt), 32'd0);
        check("turbo total", 32'(wait_total), 32'd7);
        enable = 1'b1;

        // Counter wrap, enable high every clock
        ce_mode = 1; ce_3m58_p = 1'b1;
        repeat (35) begin
            bus(1, 0, 1, 0, 1, 1); run(10); idle(); run(2);
        end
        mem_waits = 3'd3; bus(1, 0, 1, 0, 1, 1); run(10); idle(); run(2);
        check("total at max", 32'(wait_total), 32'd255);
        mem_waits = 3'd1; bus(1, 0, 1, 0, 1, 1); run(10); idle(); run(2);
        check("total wrapped", 32'(wait_total), 32'd0);

        // Randomized traffic
        ce_mode = 2;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfrsh_n} = 6'($urandom);
                m1_waits = 3'($urandom); io_waits = 3'($urandom); mem_waits = 3'($urandom);
                enable = ($urandom_range(0, 7) != 0);
            end
            if ($urandom_range(0, 9) == 0) exwait_n = ~exwait_n;
            reset = ($urandom_range(0, 499) == 0);
            clk1();
        end
        reset = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
